// File: rtl/tqvp_vga_scanout_gen2.sv
// tqvp_vga_scanout_gen2: packed-VRAM pixel scanout with palette, scroll offset and CPU stall
module tqvp_vga_scanout_gen2 #(
  parameter int PIXEL_COUNT = 320,
  parameter int BPP = 2,
  parameter int IDX_W = 9,
  parameter int DIV_W = 7,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_wr,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_wdata,
  input  logic              wait_hblank_req,
  input  logic              wait_frame_req,
  input  logic              new_scanline,
  input  logic              new_frame,
  input  logic              blank,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [5:0]        rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              row_irq,
  output logic              busy,
  output logic [IDX_W-1:0]  scan_index
);
  localparam int VW = (PIXEL_COUNT * BPP + 31) / 32;
  localparam int PAL_N = 2 ** BPP;
  localparam int PW = PAL_N / 4 > 1 ? PAL_N / 4 : 1;
  localparam int VA_W = VW > 1 ? $clog2(VW) : 1;
  localparam int BI_W = VA_W + 5;
  localparam logic [ADDR_W-1:0] VW_A = ADDR_W'(VW);
  localparam logic [ADDR_W-1:0] PAL_A = ADDR_W'(VW);
  localparam logic [ADDR_W-1:0] CFG0_A = ADDR_W'(VW + PW);
  localparam logic [ADDR_W-1:0] CFG1_A = ADDR_W'(VW + PW + 1);
  localparam logic [IDX_W:0] PC = (IDX_W + 1)'(PIXEL_COUNT);

  typedef enum logic [1:0] {IDLE, WAIT_HB, WAIT_FR, WAIT_VIS} state_t;

  logic [31:0]      vram [2**VA_W];
  logic [5:0]       pal [PAL_N];
  logic [IDX_W-1:0] stride, start_index, idx, row_base, row_next, idx_next;
  logic [DIV_W-1:0] x_div, y_div, px, py;
  logic [BI_W-1:0]  bit_idx;
  logic [31:0]      cur_word;
  logic [BPP-1:0]   pix;
  state_t           state, state_nx;

  function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W:0] a);
    return a >= PC ? IDX_W'(a - PC) : IDX_W'(a);
  endfunction

  // pixel i lives at bit i*BPP of the flat VRAM; BPP in {1,2,4} never straddles a word
  assign bit_idx = BI_W'(idx) * BI_W'(BPP);
  assign cur_word = vram[bit_idx[5 +: VA_W]];
  assign pix = cur_word[bit_idx[4:0] +: BPP];
  assign row_next = wrap({1'b0, row_base} + {1'b0, stride});
  assign idx_next = wrap({1'b0, idx} + (IDX_W + 1)'(1));
  assign scan_index = idx;
  assign busy = state != IDLE;

  // VRAM word writes; contents deliberately left unreset
  always_ff @(posedge clk)
    if (reg_wr && reg_addr < VW_A) vram[reg_addr[VA_W-1:0]] <= reg_wdata;

  // palette and scan configuration registers; out-of-range stride/start collapse to 0
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 0; k < PAL_N; k++) pal[k] <= k == 0 ? 6'h10 : k == 1 ? 6'h0B : k == 3 ? 6'h3F : 6'h00;
      stride <= IDX_W'(20);
      x_div <= DIV_W'(51);
      y_div <= DIV_W'(1);
      start_index <= '0;
    end else begin
      for (int k = 0; k < PAL_N; k++)
        if (reg_wr && reg_addr == PAL_A + ADDR_W'(k / 4)) pal[k] <= reg_wdata[(k % 4) * 8 +: 6];
      if (reg_wr && reg_addr == CFG0_A) begin
        stride <= {1'b0, reg_wdata[IDX_W-1:0]} >= PC ? '0 : reg_wdata[IDX_W-1:0];
        x_div <= reg_wdata[16 +: DIV_W];
      end
      if (reg_wr && reg_addr == CFG1_A) begin
        y_div <= reg_wdata[DIV_W-1:0];
        start_index <= {1'b0, reg_wdata[16 +: IDX_W]} >= PC ? '0 : reg_wdata[16 +: IDX_W];
      end
    end

  // scan counters: frame start beats line start beats blank beats visible stepping
  always_ff @(posedge clk)
    if (rst) begin
      px <= '0;
      py <= '0;
      idx <= '0;
      row_base <= '0;
      row_irq <= 1'b0;
    end else begin
      row_irq <= 1'b0;
      if (new_frame) begin
        px <= '0;
        py <= '0;
        idx <= start_index;
        row_base <= start_index;
      end else if (new_scanline) begin
        px <= '0;
        if (py == y_div) begin
          py <= '0;
          row_base <= row_next;
          idx <= row_next;
          row_irq <= 1'b1;
        end else begin
          py <= py + 1'b1;
          idx <= row_base;
        end
      end else if (blank) px <= '0;
      else if (px == x_div) begin
        px <= '0;
        idx <= idx_next;
      end else px <= px + 1'b1;
    end

  // colour output and sync delay, both one cycle behind the scan index
  always_ff @(posedge clk)
    if (rst) begin
      rgb <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb <= blank ? 6'h00 : pal[pix];
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end

  // stall state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;

  // a new request always re-arms; otherwise wait for the matching release event
  always_comb begin
    state_nx = state;
    state_nx = wait_hblank_req ? WAIT_HB :
               wait_frame_req ? WAIT_FR :
               (state == WAIT_HB && new_scanline) ? IDLE :
               (state == WAIT_FR && new_frame) ? WAIT_VIS :
               (state == WAIT_VIS && !blank) ? IDLE : state;
  end
endmodule
